// File: rtl/branch_decoder_unit_pkg.sv
// branch_decoder_unit_pkg: next-PC select encodings shared by the branch decoder and hazard unit
package branch_decoder_unit_pkg;
  typedef enum logic [2:0] {
    PcPlus4  = 3'd0,
    PcBranch = 3'd1,
    PcJal    = 3'd2,
    PcJalr   = 3'd3,
    PcTrap   = 3'd4,
    PcMret   = 3'd5
  } pc_src_t;
endpackage

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: hazard classes, rs2 usage flag and the register match helper
package hazard_unit_pkg;
  localparam int RegW = 5;
  typedef enum logic [1:0] {
    NoHazard      = 2'd0,
    HazardDecode  = 2'd1,
    HazardExecute = 2'd2
  } hazard_t;
  typedef enum logic {
    RsOne  = 1'b0,
    RsBoth = 1'b1
  } rs_used_t;
  // x0 is hardwired to zero, so a write to it never creates a dependency
  function automatic logic match(input logic [RegW-1:0] rs, input logic [RegW-1:0] rd,
                                 input logic we, input logic en);
    return (rs == rd) && (rd != '0) && we && en;
  endfunction
endpackage

// File: rtl/hazard_unit_data_hazard_detector.sv
// data_hazard_detector: RAW hazard check for one source register against EX and MEM
module data_hazard_detector
  import hazard_unit_pkg::*;
(
  input  logic [RegW-1:0] rs,
  input  logic [RegW-1:0] rd_ex,
  input  logic [RegW-1:0] rd_mem,
  input  logic            reg_we_ex,
  input  logic            reg_we_mem,
  input  logic            mem_rd_en_ex,
  input  logic            mem_rd_en_mem,
  input  logic            rd_complete_ex,
  input  logic            st,
  input  hazard_t         hazard_type,
  output logic            hazard
);
  logic decode_hit;
  logic execute_hit;
  assign decode_hit  = match(rs, rd_ex, reg_we_ex, !rd_complete_ex) ||
                       match(rs, rd_mem, reg_we_mem, mem_rd_en_mem);
  assign execute_hit = match(rs, rd_ex, reg_we_ex, mem_rd_en_ex && !st);
  assign hazard = (hazard_type == HazardDecode)  ? decode_hit :
                  (hazard_type == HazardExecute) ? execute_hit : 1'b0;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: combinational stall/flush control for the 5-stage pipeline
module hazard_unit
  import hazard_unit_pkg::*;
  import branch_decoder_unit_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  hazard_t         hazard_type,
  input  rs_used_t        rs_used,
  input  pc_src_t         pc_src,
  input  logic            interrupt,
  input  logic            flush_all,
  input  logic [RegW-1:0] rs1_id,
  input  logic [RegW-1:0] rs2_id,
  input  logic [RegW-1:0] rd_ex,
  input  logic [RegW-1:0] rd_mem,
  input  logic            reg_we_ex,
  input  logic            reg_we_mem,
  input  logic            mem_rd_en_ex,
  input  logic            mem_rd_en_mem,
  input  logic            store_id,
  input  logic            rd_complete_ex,
  output logic            stall_if,
  output logic            stall_id,
  output logic            stall_ex,
  output logic            stall_mem,
  output logic            stall_wb,
  output logic            flush_id,
  output logic            flush_ex,
  output logic            flush_mem,
  output logic            flush_wb
);
  logic            unused;
  logic [RegW-1:0] rs2_eff;
  logic            hazard_rs1;
  logic            hazard_rs2;
  logic            data_stall;
  assign unused  = &{1'b0, clock, reset};
  assign rs2_eff = (rs_used == RsBoth) ? rs2_id : '0;
  data_hazard_detector u_rs1 (
    .rs             (rs1_id),
    .rd_ex          (rd_ex),
    .rd_mem         (rd_mem),
    .reg_we_ex      (reg_we_ex),
    .reg_we_mem     (reg_we_mem),
    .mem_rd_en_ex   (mem_rd_en_ex),
    .mem_rd_en_mem  (mem_rd_en_mem),
    .rd_complete_ex (rd_complete_ex),
    .st             (1'b0),
    .hazard_type    (hazard_type),
    .hazard         (hazard_rs1)
  );
  // store data is read late, so a load in EX can forward to it without a stall
  data_hazard_detector u_rs2 (
    .rs             (rs2_eff),
    .rd_ex          (rd_ex),
    .rd_mem         (rd_mem),
    .reg_we_ex      (reg_we_ex),
    .reg_we_mem     (reg_we_mem),
    .mem_rd_en_ex   (mem_rd_en_ex),
    .mem_rd_en_mem  (mem_rd_en_mem),
    .rd_complete_ex (rd_complete_ex),
    .st             (store_id),
    .hazard_type    (hazard_type),
    .hazard         (hazard_rs2)
  );
  assign data_stall = hazard_rs1 || hazard_rs2;
  assign stall_if   = data_stall;
  assign stall_id   = data_stall;
  assign flush_ex   = data_stall || flush_all;
  assign flush_id   = flush_all || interrupt || (pc_src != PcPlus4);
  assign stall_ex   = interrupt;
  assign stall_mem  = interrupt;
  assign stall_wb   = interrupt;
  assign flush_mem  = flush_all;
  assign flush_wb   = flush_all;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vector table, multi-cycle sequences and random regression for hazard_unit
module tb_hazard_unit;
  import hazard_unit_pkg::*;
  import branch_decoder_unit_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b0;
  hazard_t hazard_type;
  rs_used_t rs_used;
  pc_src_t pc_src;
  logic interrupt, flush_all, reg_we_ex, reg_we_mem, mem_rd_en_ex, mem_rd_en_mem;
  logic store_id, rd_complete_ex;
  logic [4:0] rs1_id, rs2_id, rd_ex, rd_mem;
  logic stall_if, stall_id, stall_ex, stall_mem, stall_wb;
  logic flush_id, flush_ex, flush_mem, flush_wb;
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  hazard_unit dut (
    .clock(clock), .reset(reset), .hazard_type(hazard_type), .rs_used(rs_used),
    .pc_src(pc_src), .interrupt(interrupt), .flush_all(flush_all),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex), .rd_mem(rd_mem),
    .reg_we_ex(reg_we_ex), .reg_we_mem(reg_we_mem),
    .mem_rd_en_ex(mem_rd_en_ex), .mem_rd_en_mem(mem_rd_en_mem),
    .store_id(store_id), .rd_complete_ex(rd_complete_ex),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .stall_wb(stall_wb), .flush_id(flush_id),
    .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb)
  );
  typedef struct {
    string      name;
    logic [1:0] ht;
    logic       ru;
    logic [2:0] pc;
    logic       intr, fa;
    logic [4:0] rs1, rs2, rde, rdm;
    logic       wee, wem, mre, mrm, st, rc;
    logic [8:0] exp;
  } vec_t;
  vec_t vecs[$];
  // output order: stall_if stall_id stall_ex stall_mem stall_wb flush_id flush_ex flush_mem flush_wb
  function automatic logic [8:0] outs();
    return {stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex, flush_mem, flush_wb};
  endfunction
  task automatic apply(input vec_t v);
    hazard_type = hazard_t'(v.ht); rs_used = rs_used_t'(v.ru); pc_src = pc_src_t'(v.pc);
    interrupt = v.intr; flush_all = v.fa; rs1_id = v.rs1; rs2_id = v.rs2;
    rd_ex = v.rde; rd_mem = v.rdm; reg_we_ex = v.wee; reg_we_mem = v.wem;
    mem_rd_en_ex = v.mre; mem_rd_en_mem = v.mrm; store_id = v.st; rd_complete_ex = v.rc;
  endtask
  task automatic check(input string name, input logic [8:0] exp);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, outs(), exp);
    end
  endtask
  function automatic vec_t mk(input string name, input logic [1:0] ht, input logic ru,
      input logic [2:0] pc, input logic intr, input logic fa,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rde, input logic [4:0] rdm,
      input logic wee, input logic wem, input logic mre, input logic mrm,
      input logic st, input logic rc, input logic [8:0] exp);
    vec_t v;
    v.name = name; v.ht = ht; v.ru = ru; v.pc = pc; v.intr = intr; v.fa = fa;
    v.rs1 = rs1; v.rs2 = rs2; v.rde = rde; v.rdm = rdm; v.wee = wee; v.wem = wem;
    v.mre = mre; v.mrm = mrm; v.st = st; v.rc = rc; v.exp = exp;
    return v;
  endfunction
  // independent reference of the stall/flush equations
  function automatic logic [8:0] ref_model(input vec_t v);
    logic [4:0] r2;
    logic h1, h2, ds, redirect;
    r2 = v.ru ? v.rs2 : 5'd0;
    h1 = 1'b0; h2 = 1'b0;
    if (v.ht == 2'd1) begin
      h1 = (v.rs1 == v.rde && v.rde != 0 && v.wee && !v.rc) || (v.rs1 == v.rdm && v.rdm != 0 && v.wem && v.mrm);
      h2 = (r2 == v.rde && v.rde != 0 && v.wee && !v.rc) || (r2 == v.rdm && v.rdm != 0 && v.wem && v.mrm);
    end else if (v.ht == 2'd2) begin
      h1 = v.rs1 == v.rde && v.rde != 0 && v.wee && v.mre;
      h2 = r2 == v.rde && v.rde != 0 && v.wee && v.mre && !v.st;
    end
    ds = h1 | h2;
    redirect = v.pc != 3'd0;
    return {ds, ds, v.intr, v.intr, v.intr, v.fa | v.intr | redirect, ds | v.fa, v.fa, v.fa};
  endfunction
  vec_t idle, v;
  initial begin
    idle = mk("idle", 2'd0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000000000);
    vecs.push_back(mk("dec_ex_raw",     2'd1, 0, 3'd0, 0, 0, 5, 0, 5, 0, 1, 0, 0, 0, 0, 0, 9'b110000100));
    vecs.push_back(mk("dec_ex_done",    2'd1, 0, 3'd0, 0, 0, 5, 0, 5, 0, 1, 0, 0, 0, 0, 1, 9'b000000000));
    vecs.push_back(mk("dec_x0",         2'd1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 9'b000000000));
    vecs.push_back(mk("dec_rs2_unused", 2'd1, 0, 3'd0, 0, 0, 0, 7, 0, 7, 0, 1, 0, 1, 0, 0, 9'b000000000));
    vecs.push_back(mk("dec_rs2_used",   2'd1, 1, 3'd0, 0, 0, 0, 7, 0, 7, 0, 1, 0, 1, 0, 0, 9'b110000100));
    vecs.push_back(mk("dec_mem_noload", 2'd1, 0, 3'd0, 0, 0, 3, 0, 0, 3, 0, 1, 0, 0, 0, 0, 9'b000000000));
    vecs.push_back(mk("exe_store_data", 2'd2, 1, 3'd0, 0, 0, 0, 9, 9, 0, 1, 0, 1, 0, 1, 0, 9'b000000000));
    vecs.push_back(mk("exe_rs1_load",   2'd2, 1, 3'd0, 0, 0, 9, 9, 9, 0, 1, 0, 1, 0, 1, 0, 9'b110000100));
    vecs.push_back(mk("exe_no_load",    2'd2, 1, 3'd0, 0, 0, 9, 9, 9, 0, 1, 0, 0, 0, 1, 0, 9'b000000000));
    vecs.push_back(mk("exe_rs2_nostore",2'd2, 1, 3'd0, 0, 0, 0, 9, 9, 0, 1, 0, 1, 0, 0, 0, 9'b110000100));
    vecs.push_back(mk("exe_no_we",      2'd2, 1, 3'd0, 0, 0, 9, 0, 9, 0, 0, 0, 1, 0, 0, 0, 9'b000000000));
    vecs.push_back(mk("nohaz_match",    2'd0, 1, 3'd0, 0, 0, 5, 5, 5, 5, 1, 1, 1, 1, 0, 0, 9'b000000000));
    vecs.push_back(mk("redirect",       2'd0, 0, 3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000001000));
    vecs.push_back(mk("redirect_jalr",  2'd0, 0, 3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000001000));
    vecs.push_back(mk("flush_all",      2'd0, 0, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000001111));
    vecs.push_back(mk("interrupt",      2'd0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b001111000));
    vecs.push_back(mk("intr_and_raw",   2'd1, 0, 3'd0, 1, 0, 5, 0, 5, 0, 1, 0, 0, 0, 0, 0, 9'b111111100));
    vecs.push_back(mk("flush_and_intr", 2'd0, 0, 3'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b001111111));
    apply(idle);
    reset = 1'b1;
    #2 check("reset_idle", 9'b000000000);
    apply(vecs[0]);
    #1 check("reset_raw", 9'b110000100);
    @(negedge clock) reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock) apply(vecs[i]);
      #1 check(vecs[i].name, vecs[i].exp);
    end
    // a hazard held over several edges keeps stalling, and clears the moment it is removed
    @(negedge clock) apply(vecs[0]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock) #1 check("hold_stall", 9'b110000100);
    end
    apply(idle);
    #1 check("release_stall", 9'b000000000);
    // reset pulsing mid-stream must not disturb outputs
    apply(vecs[15]);
    reset = 1'b1;
    #1 check("intr_in_reset", 9'b001111000);
    @(posedge clock) #1 reset = 1'b0;
    #1 check("intr_after_reset", 9'b001111000);
    for (int i = 0; i < 10000; i++) begin
      v.name = "random";
      v.ht = 2'($urandom_range(0, 2)); v.ru = 1'($urandom); v.pc = 3'($urandom_range(0, 5));
      v.intr = ($urandom_range(0, 7) == 0); v.fa = ($urandom_range(0, 7) == 0);
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
      v.rde = 5'($urandom_range(0, 3)); v.rdm = 5'($urandom_range(0, 3));
      v.wee = 1'($urandom); v.wem = 1'($urandom); v.mre = 1'($urandom); v.mrm = 1'($urandom);
      v.st = 1'($urandom); v.rc = 1'($urandom);
      v.pc = ($urandom_range(0, 1) == 0) ? 3'd0 : v.pc;
      apply(v);
      #1 check("random", ref_model(v));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage PoliRISC-V core (IF/ID/EX/MEM/WB).
- Detects RAW data hazards between source registers in ID and destinations in EX/MEM, and control events (taken branch/jump, flush-all, interrupt).
- Drives per-stage stall and flush controls.
- Datapath is purely combinational; clock and reset exist for interface uniformity with the other core blocks.

Parameters:
- none (register index width fixed at 5)

Ports:
- clock  input  1  core clock; no state is clocked by it
- reset  input  1  asynchronous, active-high reset; no state, so it has no effect on outputs
- hazard_type  input  hazard_t  hazard class of the instruction in ID
- rs_used  input  rs_used_t (1 bit)  1 = instruction in ID reads rs2; 0 = rs2 ignored
- pc_src  input  pc_src_t  next-PC select; any value other than PcPlus4 means redirect
- interrupt  input  1  interrupt being taken
- flush_all  input  1  flush whole pipeline
- rs1_id, rs2_id  input  5 each  source registers in ID
- rd_ex, rd_mem  input  5 each  destination registers in EX and MEM
- reg_we_ex, reg_we_mem  input  1 each  register-file write enable in EX and MEM
- mem_rd_en_ex, mem_rd_en_mem  input  1 each  load in EX and MEM
- store_id  input  1  instruction in ID is a store
- rd_complete_ex  input  1  EX result is already available for forwarding
- stall_if, stall_id, stall_ex, stall_mem, stall_wb  output  1 each  hold the stage register
- flush_id, flush_ex, flush_mem, flush_wb  output  1 each  bubble the stage register

Behaviour:
- All outputs are combinational functions of the current inputs; zero latency; no internal state.
- Outputs are valid in the same cycle as the inputs, and also while reset is asserted.

Match function:
- match(rs, rd, we, en) = (rs == rd) && (rd != 0) && we && en.
- rd = x0 never matches.

Per-source hazard, evaluated separately for rs1 and rs2:
- HazardDecode: match(rs, rd_ex, reg_we_ex, !rd_complete_ex) OR match(rs, rd_mem, reg_we_mem, mem_rd_en_mem).
- HazardExecute: match(rs, rd_ex, reg_we_ex, mem_rd_en_ex && !st), i.e. a load-use hazard.
- NoHazard, and any unlisted encoding: no hazard.

Source operands:
- rs1 path uses st = 0.
- rs2 path uses st = store_id, so store data does not stall on a load in EX.
- rs2 path uses rs = rs_used ? rs2_id : 0, so an unused rs2 never hazards.

data_stall = hazard(rs1) OR hazard(rs2).

Output equations:
- stall_if = data_stall.
- stall_id = data_stall.
- flush_ex = data_stall OR flush_all.
- flush_id = flush_all OR interrupt OR (pc_src != PcPlus4).
- stall_ex = interrupt.
- stall_mem = interrupt.
- stall_wb = interrupt.
- flush_mem = flush_all.
- flush_wb = flush_all.

Simultaneous events:
- Outputs are simple ORs; no priority masking.
- stall_x and flush_x may both be 1 (e.g. flush_all with interrupt). Pipeline registers must give flush precedence over stall.

Decomposition:
- hazard_unit_pkg: hazard_t enum {NoHazard, HazardDecode, HazardExecute}; rs_used_t 1-bit enum (0 = rs1 only, 1 = rs1 and rs2).
- branch_decoder_unit_pkg: owns pc_src_t, including PcPlus4.
- Sub-module data_hazard_detector: one instance each for rs1 and rs2. Inputs rs, rd_ex, rd_mem, write enables, load enables, rd_complete_ex, st, hazard_type; output hazard.

Test Plan:
- Decode RAW from EX: HazardDecode, rs1_id=5, rd_ex=5, reg_we_ex=1, rd_complete_ex=0, all others 0, pc_src=PcPlus4 -> stall_if=stall_id=flush_ex=1, all other outputs 0. Same with rd_complete_ex=1 -> all outputs 0.
- x0 and unused rs2: HazardDecode, rs1_id=rd_mem=0, reg_we_mem=mem_rd_en_mem=1 -> no stall. Then rs2_id=rd_mem=7, rs_used=0 -> no stall; rs_used=1 -> stall_if=stall_id=flush_ex=1.
- Load-use: HazardExecute, rs2_id=rd_ex=9, rs_used=1, reg_we_ex=1, mem_rd_en_ex=1, store_id=1 -> no stall. Same with rs1_id=9 instead -> stall. Same with mem_rd_en_ex=0 -> no stall.
- Control: pc_src != PcPlus4 only -> flush_id=1, all else 0. flush_all=1 -> flush_id=flush_ex=flush_mem=flush_wb=1, stalls 0.
- Interrupt: interrupt=1 -> flush_id=stall_ex=stall_mem=stall_wb=1, stall_if=stall_id=0. Combined with a HazardDecode match -> additionally stall_if=stall_id=flush_ex=1.
- Random regression: 10000 random input vectors; compare every output against a reference model of the equations above.
